// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access size codes, LSU FSM encoding and an
// alignment helper used by both the load/store unit and the data memory.
package mem_pkg;

    typedef enum logic [1:0] {
        SizeNone = 2'b00,
        SizeByte = 2'b01,
        SizeHalf = 2'b10,
        SizeWord = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StResp  = 2'b10
    } lsu_state_e;

    // Natural alignment only; byte accesses are never misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SizeHalf) && addr_lo[0]) ||
               ((size == SizeWord) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response channel of the load/store unit.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_size,
        output req_unsigned,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        output resp_ready,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_size,
        input  req_unsigned,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        input  resp_ready,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of the
// memory word and sign- or zero-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        unique case (addr_lo)
            2'b00: lane_b = word[7:0];
            2'b01: lane_b = word[15:8];
            2'b10: lane_b = word[23:16];
            2'b11: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];

        result = '0;
        case (size)
            SizeByte: result = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SizeHalf: result = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            SizeWord: result = word;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one pipeline request, issues it
// to the data memory for one cycle, then holds the response until taken.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned DM_AW = 9
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic             dm_DMWr,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic [1:0]       dm_memOp,
    input  logic [31:0]      dm_dout
);

    lsu_state_e state_q, state_d;

    logic             we_q;
    logic             uns_q;
    logic [DM_AW-1:0] dm_addr_q;
    logic [31:0]      dm_din_q;
    logic [1:0]       dm_memop_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic        accept;
    logic        size_bad;
    logic        range_bad;
    logic        req_legal;
    logic [31:0] load_data;

    assign accept    = (state_q == StIdle) && bus.req_valid;
    assign size_bad  = (bus.req_size == SizeNone);
    assign range_bad = ((bus.req_addr >> DM_AW) != 32'd0);
    assign req_legal = !size_bad && !range_bad && !misaligned(bus.req_size, bus.req_addr[1:0]);

    load_align u_load_align (
        .word        (dm_dout),
        .addr_lo     (dm_addr_q[1:0]),
        .size        (dm_memop_q),
        .is_unsigned (uns_q),
        .result      (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_legal ? StIssue : StResp;
                end
            end
            StIssue: state_d = StResp;
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        // Reset during ISSUE must kill the write in that very cycle.
        dm_DMWr        = (state_q == StIssue) && we_q && !rst;
    end

    // dm_* registers only load on a legal accept, so they hold their last
    // issued values through IDLE, RESP and illegal requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            dm_addr_q    <= '0;
            dm_din_q     <= '0;
            dm_memop_q   <= SizeWord;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q  <= bus.req_we;
                uns_q <= bus.req_unsigned;
                if (req_legal) begin
                    dm_addr_q  <= bus.req_addr[DM_AW-1:0];
                    dm_din_q   <= bus.req_wdata;
                    dm_memop_q <= bus.req_size;
                    resp_err_q <= 1'b0;
                end else begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b1;
                end
            end
            if (state_q == StIssue) begin
                resp_rdata_q <= we_q ? 32'd0 : load_data;
                resp_err_q   <= 1'b0;
            end
        end
    end

    assign dm_addr        = dm_addr_q;
    assign dm_din         = dm_din_q;
    assign dm_memOp       = dm_memop_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a lane-merging data-memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic        dm_DMWr;
    logic [8:0]  dm_addr;
    logic [31:0] dm_din;
    logic [1:0]  dm_memOp;
    logic [31:0] dm_dout;
    logic [31:0] mem [0:127];

    int vectors;
    int miscompares;

    int          lat;
    int          wr_cnt;
    logic [31:0] rdata;
    logic        err;
    logic [8:0]  wr_addr;
    logic [1:0]  wr_op;
    logic [31:0] wr_din;

    load_store_unit_if bus ();

    load_store_unit #(
        .DM_AW (9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dm_DMWr  (dm_DMWr),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_memOp (dm_memOp),
        .dm_dout  (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr[8:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (dm_DMWr) begin
            case (dm_memOp)
                2'b01:   mem[dm_addr[8:2]][8*dm_addr[1:0] +: 8] <= dm_din[7:0];
                2'b10:   mem[dm_addr[8:2]][16*dm_addr[1] +: 16] <= dm_din[15:0];
                2'b11:   mem[dm_addr[8:2]] <= dm_din;
                default: ;
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the handshake.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat     = 0;
        wr_cnt  = 0;
        wr_addr = '0;
        wr_op   = '0;
        wr_din  = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (dm_DMWr) begin
                wr_cnt++;
                wr_addr = dm_addr;
                wr_op   = dm_memOp;
                wr_din  = dm_din;
            end
            if (bus.resp_valid) break;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        check("resp_valid_seen", bus.resp_valid, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b1;
        mem_init         = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;

        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", bus.resp_err, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_dm_din", dm_din, 0);
        check("rst_dm_memop", dm_memOp, 2'b11);
        check("rst_dm_we", dm_DMWr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_init = 1'b0;

        // sw then lw of a full word
        do_req(1'b1, 2'b11, 1'b0, 32'h010, 32'hDEADBEEF);
        check("sw_lat", lat, 2);
        check("sw_wr_cnt", wr_cnt, 1);
        check("sw_wr_addr", wr_addr, 9'h010);
        check("sw_wr_op", wr_op, 2'b11);
        check("sw_wr_din", wr_din, 32'hDEADBEEF);
        check("sw_rdata", rdata, 0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        check("idle_dm_addr_hold", dm_addr, 9'h010);
        do_req(1'b0, 2'b11, 1'b0, 32'h010, 32'h0);
        check("lw_lat", lat, 2);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_err", err, 0);

        // byte and halfword loads with sign/zero extension
        do_req(1'b1, 2'b11, 1'b0, 32'h010, 32'h80FF7F01);
        check("sw2_mem", mem[4], 32'h80FF7F01);
        do_req(1'b0, 2'b01, 1'b0, 32'h013, 32'h0);
        check("lb_013", rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'b01, 1'b1, 32'h013, 32'h0);
        check("lbu_013", rdata, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h010, 32'h0);
        check("lb_010", rdata, 32'h00000001);
        do_req(1'b0, 2'b10, 1'b0, 32'h012, 32'h0);
        check("lh_012", rdata, 32'hFFFF80FF);
        do_req(1'b0, 2'b10, 1'b1, 32'h010, 32'h0);
        check("lhu_010", rdata, 32'h00007F01);
        do_req(1'b1, 2'b10, 1'b0, 32'h012, 32'h00001234);
        check("sh_wr_op", wr_op, 2'b10);
        check("sh_wr_addr", wr_addr, 9'h012);
        check("sh_mem", mem[4], 32'h12347F01);

        // illegal requests: error in N+1, no write, memory untouched
        do_req(1'b1, 2'b11, 1'b0, 32'h002, 32'hFFFFFFFF);
        check("sw_mis_lat", lat, 1);
        check("sw_mis_err", err, 1);
        check("sw_mis_wr", wr_cnt, 0);
        check("sw_mis_mem", mem[0], 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h011, 32'h0);
        check("lh_mis_lat", lat, 1);
        check("lh_mis_err", err, 1);
        check("lh_mis_rdata", rdata, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h010, 32'hFFFFFFFF);
        check("sz0_lat", lat, 1);
        check("sz0_err", err, 1);
        check("sz0_wr", wr_cnt, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h200, 32'h0);
        check("lw_oor_lat", lat, 1);
        check("lw_oor_err", err, 1);
        check("illegal_mem", mem[4], 32'h12347F01);
        check("illegal_dm_addr_hold", dm_addr, 9'h012);

        // response backpressure; a new request must be ignored meanwhile
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'b11;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h010;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_n2", bus.resp_valid, 1);
        check("bp_rdata_n2", bus.resp_rdata, 32'h12347F01);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 32'h000;
        bus.req_wdata = 32'hAAAAAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", bus.resp_valid, 1);
            check("bp_rdata", bus.resp_rdata, 32'h12347F01);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_dm_we", dm_DMWr, 0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_done_ready", bus.req_ready, 1);
        check("bp_done_valid", bus.resp_valid, 0);
        check("bp_ignored_mem", mem[0], 0);
        @(posedge clk);
        #1;

        // reset while a response is pending drops it
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'b11;
        bus.req_addr = 32'h010;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rresp_valid", bus.resp_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("rresp_dropped", bus.resp_valid, 0);
        check("rresp_rdata", bus.resp_rdata, 0);
        check("rresp_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // reset during the ISSUE cycle of a store suppresses the write
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b11;
        bus.req_addr = 32'h020;
        bus.req_wdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rissue_dm_we", dm_DMWr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rissue_ready", bus.req_ready, 1);
        check("rissue_no_resp", bus.resp_valid, 0);
        check("rissue_mem", mem[8], 0);
        @(negedge clk);
        check("rissue_no_resp2", bus.resp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DM_AW, default 9, meaning the data-memory byte-address width (128 words).
REQ-002 SHALL have port clk  in  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  in  1  pipeline request present.
REQ-005 SHALL have port req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  access size: 01 byte, 10 half, 11 word, 00 illegal.
REQ-008 SHALL have port req_unsigned  in  1  1 = zero-extend load result, 0 = sign-extend.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1  response present.
REQ-012 SHALL have port resp_ready  in  1  pipeline accepts the response.
REQ-013 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  out  1  request was misaligned, out of range or illegal-size.
REQ-015 SHALL have port dm_DMWr  out  1  data-memory write enable.
REQ-016 SHALL have port dm_addr  out  DM_AW  data-memory byte address.
REQ-017 SHALL have port dm_din  out  32  data-memory write data, passed unshifted because the memory merges lanes itself.
REQ-018 SHALL have port dm_memOp  out  2  data-memory size code, equal to the registered req_size.
REQ-019 SHALL have port dm_dout  in  32  combinational data-memory read word.

Function
REQ-020 SHALL implement the FSM states IDLE, ISSUE and RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE.
REQ-022 SHALL, in IDLE on req_valid, register we/size/unsigned/addr/wdata.
REQ-023 SHALL move from IDLE to ISSUE when the accepted request is legal, and to RESP with err=1 when it is not.
REQ-024 SHALL treat a request as illegal when: size 00; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:DM_AW]!=0.
REQ-025 SHALL, in ISSUE, last exactly one cycle and drive dm_addr=addr[DM_AW-1:0], dm_memOp=size, dm_din=wdata and dm_DMWr=we & ~rst, then go to RESP.
REQ-026 SHALL drive dm_DMWr=0 in every state other than ISSUE, including illegal requests.
REQ-027 SHALL, for loads, capture dm_dout at the end of ISSUE and extract the result:
- byte: lane addr[1:0] (00 -> [7:0] ... 11 -> [31:24]);
- half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16];
- word: the full word;
- then sign- or zero-extend per the unsigned field.
REQ-028 SHALL, in RESP, assert resp_valid and hold resp_rdata/resp_err stable until resp_ready=1, then go to IDLE.
REQ-029 SHALL have a legal-request latency of accept edge N -> ISSUE in cycle N+1 -> resp_valid in cycle N+2; an illegal request gives resp_valid in cycle N+1.
REQ-030 SHALL hold dm_addr/dm_memOp/dm_din at their last values outside ISSUE.

Reset
REQ-031 SHALL, on rst, clear at the next edge: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, dm_addr=0, dm_din=0, dm_memOp=11.
REQ-032 SHALL have rst asserted during ISSUE suppress the write in that cycle, with no response produced.
REQ-033 SHALL have rst asserted during RESP drop the pending response.

Structure
REQ-034 SHALL place the size codes (BYTE=01, HALF=10, WORD=11) and the FSM state encoding in the shared package mem_pkg, which the data memory also uses.
REQ-035 SHALL implement load extraction and extension as sub-module load_align (combinational: word, addr[1:0], size, unsigned -> 32-bit result).

Verification
REQ-036 SHALL cover: sw addr 0x010 data 0xDEADBEEF -> one-cycle dm_DMWr=1, dm_addr=0x010, dm_memOp=11; then lw 0x010 -> resp_rdata 0xDEADBEEF in cycle N+2.
REQ-037 SHALL cover: word 0x80FF7F01 at 0x010; lb 0x013 -> 0xFFFFFF80; lbu 0x013 -> 0x00000080; lb 0x010 -> 0x00000001.
REQ-038 SHALL cover: same word; lh 0x012 -> 0xFFFF80FF; lhu 0x010 -> 0x00007F01; sh 0x012 data 0x1234 -> memory word becomes 0x12347F01.
REQ-039 SHALL cover: sw 0x002, lh 0x011, size 00, lw 0x200 -> each gives resp_err=1 in cycle N+1, dm_DMWr never 1, memory unchanged.
REQ-040 SHALL cover: resp_ready low for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0, and a new req_valid is ignored.
REQ-041 SHALL cover: rst during the ISSUE cycle of sw 0x020 data 0x5A5A5A5A -> memory word 0x020 unchanged, no resp_valid, req_ready=1 next cycle.
